muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit sitting directly downstream of the register bank.
- Consumes the two read-port operands (rd1/rd2), computes over multiple cycles, and produces a write-back request (enable, destination, data) that drives the register bank's RegW/Rd/wd write port.
- Holds HI/LO result registers for the full 64-bit product or the remainder/quotient pair.

Parameters:
- WIDTH, 32, operand and result width.
- REG_ADDR_W, 5, register address width.
- NUM_REGS, 17, register count (R0-R15 plus SP at index 16); legal destinations are 1..NUM_REGS-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  00=MUL (signed), 01=MULU, 10=DIV (signed), 11=DIVU.
- a  in  WIDTH  operand A (rd1): multiplicand or dividend.
- b  in  WIDTH  operand B (rd2): multiplier or divisor.
- dest  in  REG_ADDR_W  destination register for the LO result.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the result is valid.
- hi  out  WIDTH  product[63:32] or remainder.
- lo  out  WIDTH  product[31:0] or quotient.
- wr_en  out  1  write-back strobe to the register bank.
- wr_rd  out  REG_ADDR_W  write-back address.
- wr_data  out  WIDTH  write-back data; always equals lo.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, iteration counter 0. Reset during an operation aborts it with no done and no wr_en.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: when start=1, latch op, dest, |a| and |b| (absolute values for signed ops, raw values for unsigned ops), and the result signs. Then go to CALC with counter=0; busy=1 from the next cycle.
- IDLE, divide by zero (b=0 on DIV/DIVU): skip CALC and go directly to FIX.
- CALC: exactly WIDTH iterations, one per cycle. Counter increments each cycle; leave for FIX after counter reaches WIDTH-1.
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring algorithm, one quotient bit per cycle.
- FIX: apply signs.
  - Product is negated if the signs of a and b differ.
  - Quotient is negated if the signs differ; remainder takes the sign of a.
  - Load hi/lo.
- DONE: done=1 and wr_en=1 for exactly one cycle, then IDLE; busy drops in the same cycle.
- Latency: start sampled at edge 0 → done high in the cycle after edge WIDTH+2 (34 for WIDTH=32). Divide by zero: done after edge 2.
- Divide by zero: lo = all ones, hi = a (unmodified dividend), for both signed and unsigned divides.
- Signed overflow (a = -2^31, b = -1, DIV): lo = -2^31 (0x80000000), hi = 0. This falls out naturally from the magnitude path; no special case is needed.
- Multiply arithmetic: lo = low half of the full signed/unsigned 64-bit product, hi = high half; no truncation flags.
- start while busy: ignored, with no queuing.
- start in the same cycle as a DONE pulse: ignored; start is accepted in IDLE only.
- Write-back suppression: wr_en is suppressed (done still pulses, hi/lo still update) when dest=0 (R0 is hardwired) or dest ≥ NUM_REGS.
- hi/lo hold their values until the next FIX or a reset.
- Inputs a, b and dest may change after the accept edge; internal copies are used.

Decomposition:
- Shared cpu package holds:
  - op encodings: OP_MUL, OP_MULU, OP_DIV, OP_DIVU.
  - FSM state encodings.
  - WIDTH, REG_ADDR_W, NUM_REGS, SP_IDX=16.
- One natural sub-module: muldiv_sign_fix, a combinational magnitude/sign pre- and post-processing block used in IDLE and FIX. The datapath and FSM stay in muldiv_unit.

Test Plan:
- Reset then MUL a=-7, b=6, dest=3 → busy for 33 cycles; done+wr_en in the cycle after edge 34; lo=-42, hi=0xFFFFFFFF, wr_rd=3, wr_data=-42.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-17, b=5 → lo=-3, hi=-2. DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=25, b=0, dest=4 → done after edge 2; lo=0xFFFFFFFF, hi=25, wr_en=1.
- DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0. DIVU a=6, b=3 with dest=0 → done=1, wr_en=0, lo=2.
- Start MUL, pulse start again at cycle 10 with other operands, then drive rst=0 at cycle 20 → second start ignored; after reset all outputs are 0, no done or wr_en seen; a new start after reset completes normally.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared widths, op encodings and FSM states for the multiply/divide unit.
package muldiv_unit_pkg;
   localparam int WIDTH      = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 17;
   localparam int SP_IDX     = 16;
   localparam int CNT_W      = $clog2(WIDTH);
   typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
   typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10, DONE = 2'b11} state_e;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand request and write-back bus between register bank and muldiv_unit.
interface muldiv_unit_if;
   import muldiv_unit_pkg::*;
   logic                  start;
   op_e                   op;
   logic [WIDTH-1:0]      a;
   logic [WIDTH-1:0]      b;
   logic [REG_ADDR_W-1:0] dest;
   logic                  busy;
   logic                  done;
   logic [WIDTH-1:0]      hi;
   logic [WIDTH-1:0]      lo;
   logic                  wr_en;
   logic [REG_ADDR_W-1:0] wr_rd;
   logic [WIDTH-1:0]      wr_data;
   modport master (output start, op, a, b, dest, input busy, done, hi, lo, wr_en, wr_rd, wr_data);
   modport slave (input start, op, a, b, dest, output busy, done, hi, lo, wr_en, wr_rd, wr_data);
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: operand magnitude extraction and result sign restoration around the unsigned core.
module muldiv_sign_fix
   import muldiv_unit_pkg::*;
(
   input  op_e                op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   ma,
   output logic [WIDTH-1:0]   mb,
   output logic               neg,
   output logic               sa,
   input  op_e                fop,
   input  logic [2*WIDTH-1:0] acc,
   input  logic               fneg,
   input  logic               fsa,
   input  logic               dz,
   input  logic [WIDTH-1:0]   araw,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);
   logic               sgn, sb;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   q, r;
   assign sgn  = ~op[0];
   assign sa   = sgn & a[WIDTH-1];
   assign sb   = sgn & b[WIDTH-1];
   assign neg  = sa ^ sb;
   assign ma   = sa ? -a : a;
   assign mb   = sb ? -b : b;
   assign prod = fneg ? -acc : acc;
   assign q    = fneg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign r    = fsa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   // divide by zero returns the untouched dividend, independent of signedness
   assign hi   = dz ? araw : fop[1] ? r : prod[2*WIDTH-1:WIDTH];
   assign lo   = dz ? '1 : fop[1] ? q : prod[WIDTH-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider with HI/LO and register write-back.
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input logic          clk,
   input logic          rst,
   muldiv_unit_if.slave bus
);
   state_e                state, nxt;
   op_e                   op_q;
   logic [REG_ADDR_W-1:0] dest_q, wr_rd_q;
   logic [WIDTH-1:0]      a_q, x_q, hi_q, lo_q, ma_c, mb_c, hi_c, lo_c;
   logic [2*WIDTH-1:0]    acc;
   logic [CNT_W-1:0]      cnt;
   logic                  neg_q, sa_q, dz_q, neg_c, sa_c;
   logic                  busy_q, done_q, wr_en_q;
   logic                  accept, dz, dest_ok;
   logic [WIDTH:0]        msum, dtry, ddiff;
   muldiv_sign_fix u_fix (
      .op(bus.op), .a(bus.a), .b(bus.b), .ma(ma_c), .mb(mb_c), .neg(neg_c), .sa(sa_c),
      .fop(op_q), .acc(acc), .fneg(neg_q), .fsa(sa_q), .dz(dz_q), .araw(a_q), .hi(hi_c), .lo(lo_c)
   );
   // done_q masks the IDLE cycle that carries the done pulse
   assign accept  = state == IDLE && bus.start && !done_q;
   assign dz      = bus.op[1] && bus.b == '0;
   assign dest_ok = dest_q != '0 && dest_q < REG_ADDR_W'(NUM_REGS);
   assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? x_q : '0};
   assign dtry    = acc[2*WIDTH-1:WIDTH-1];
   assign ddiff   = dtry - {1'b0, x_q};
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = accept ? (dz ? FIX : CALC) : IDLE;
         CALC:    nxt = cnt == CNT_W'(WIDTH-1) ? FIX : CALC;
         FIX:     nxt = DONE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) state <= !rst ? IDLE : nxt;
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_q    <= OP_MUL;
         dest_q  <= '0;
         a_q     <= '0;
         x_q     <= '0;
         acc     <= '0;
         cnt     <= '0;
         neg_q   <= 1'b0;
         sa_q    <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wr_en_q <= 1'b0;
         wr_rd_q <= '0;
      end else begin
         busy_q  <= state == CALC || state == FIX;
         done_q  <= state == DONE;
         wr_en_q <= state == DONE && dest_ok;
         if (state == DONE) wr_rd_q <= dest_q;
         if (accept) begin
            op_q   <= bus.op;
            dest_q <= bus.dest;
            a_q    <= bus.a;
            x_q    <= bus.op[1] ? mb_c : ma_c;
            acc    <= {{WIDTH{1'b0}}, bus.op[1] ? ma_c : mb_c};
            neg_q  <= neg_c;
            sa_q   <= sa_c;
            dz_q   <= dz;
            cnt    <= '0;
         end
         // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
         if (state == CALC) begin
            cnt <= cnt + 1'b1;
            acc <= !op_q[1] ? {msum, acc[WIDTH-1:1]} :
                   ddiff[WIDTH] ? {dtry[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                   {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end
         if (state == FIX) begin
            hi_q <= hi_c;
            lo_q <= lo_c;
         end
      end
   end
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_rd   = wr_rd_q;
   assign bus.wr_data = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector check of muldiv_unit latency, results, write-back and reset abort.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;
   always #5 clk = ~clk;
   muldiv_unit_if bus();
   muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));
   always @(negedge clk) if (bus.done || bus.wr_en) done_cnt++;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic run(input string tag, input op_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] dest, input int lat, input int busy_n,
                      input logic [31:0] ehi, input logic [31:0] elo, input logic ewr, input bit poke);
      int n = 0;
      int bc = 0;
      bit seen = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.dest = dest;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = 32'h5a5a1234; bus.b = 32'h0; bus.dest = 5'd9;
      while (!seen && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (bus.busy) bc++;
         if (bus.done) seen = 1;
      end
      check({tag, ".latency"}, 64'(n), 64'(lat));
      check({tag, ".busy_cycles"}, 64'(bc), 64'(busy_n));
      check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
      check({tag, ".hi"}, 64'(bus.hi), 64'(ehi));
      check({tag, ".lo"}, 64'(bus.lo), 64'(elo));
      check({tag, ".wr_en"}, 64'(bus.wr_en), 64'(ewr));
      check({tag, ".wr_data"}, 64'(bus.wr_data), 64'(elo));
      if (ewr) check({tag, ".wr_rd"}, 64'(bus.wr_rd), 64'(dest));
      if (poke) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({tag, ".done_pulse"}, 64'({bus.done, bus.wr_en}), 64'd0);
      if (poke) begin
         @(posedge clk); #1;
         check({tag, ".start_at_done_ignored"}, 64'(bus.busy), 64'd0);
      end
   endtask
   task automatic check_zero(input string tag);
      check({tag, ".ctl"}, 64'({bus.busy, bus.done, bus.wr_en}), 64'd0);
      check({tag, ".hi"}, 64'(bus.hi), 64'd0);
      check({tag, ".lo"}, 64'(bus.lo), 64'd0);
      check({tag, ".wr_rd"}, 64'(bus.wr_rd), 64'd0);
      check({tag, ".wr_data"}, 64'(bus.wr_data), 64'd0);
   endtask
   initial begin
      int d0;
      bus.start = 1'b0; bus.op = OP_MUL; bus.a = '0; bus.b = '0; bus.dest = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b1;
      run("mul_neg",   OP_MUL,  32'hFFFFFFF9, 32'd6,        5'd3,  34, 33, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b1, 0);
      run("mulu_max",  OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  34, 33, 32'hFFFFFFFE, 32'h00000001, 1'b1, 0);
      run("mul_min",   OP_MUL,  32'h80000000, 32'd2,        5'd8,  34, 33, 32'hFFFFFFFF, 32'h00000000, 1'b1, 0);
      run("div_neg",   OP_DIV,  32'hFFFFFFEF, 32'd5,        5'd1,  34, 33, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 0);
      run("div_negb",  OP_DIV,  32'd7,        32'hFFFFFFFE, 5'd6,  34, 33, 32'h00000001, 32'hFFFFFFFD, 1'b1, 0);
      run("divu",      OP_DIVU, 32'd100,      32'd7,        5'd16, 34, 33, 32'd2,        32'd14,       1'b1, 1);
      run("div_zero",  OP_DIV,  32'd25,       32'd0,        5'd4,  2,  1,  32'd25,       32'hFFFFFFFF, 1'b1, 0);
      run("div_zneg",  OP_DIV,  32'hFFFFFFFB, 32'd0,        5'd17, 2,  1,  32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 0);
      run("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd2,  34, 33, 32'd0,        32'h80000000, 1'b1, 0);
      run("divu_r0",   OP_DIVU, 32'd6,        32'd3,        5'd0,  34, 33, 32'd0,        32'd2,        1'b0, 0);
      d0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_MUL; bus.a = 32'd123; bus.b = 32'd456; bus.dest = 5'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1; bus.b = 32'd1; bus.dest = 5'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("abort.busy_before_reset", 64'(bus.busy), 64'd1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check_zero("abort");
      repeat (40) @(posedge clk);
      #1;
      check("abort.no_done", 64'(done_cnt), 64'(d0));
      run("post_rst",  OP_MUL,  32'd3,        32'hFFFFFFFB, 5'd5,  34, 33, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
